// File: rtl/ifu_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch block: widths,
// reset PC default, queue entry layout and the fetch FSM state type.
package ifu_prefetch_pkg;

    localparam int          PC_W             = 32;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // One prefetch queue entry: the fetch address and the word read there.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // RUN is normal streaming; FLUSH marks the cycle after a redirect edge.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ifu_state_e;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are forced onto a word boundary.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Bundle of the instruction-memory and decode-side signals of the fetch
// unit. The master side is the fetch unit; the slave side is the
// surrounding memory/decode logic (or a testbench standing in for it).
interface ifu_prefetch_if;
    import ifu_prefetch_pkg::*;

    logic [PC_W-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [PC_W-1:0]    dec_pc;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output if_pc,
        input  if_instr,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  if_pc,
        output if_instr,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc,
        output redirect,
        output redirect_pc
    );

endinterface

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO holding {pc, instr} prefetch entries. Flush empties
// it in one edge. The read port shows zero whenever the queue is empty so the
// decode side never sees a stale entry.
module ifu_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic [PTR_W:0] count,
    output logic         full,
    output logic         empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_write;
    logic             do_read;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_read  = pop & ~empty & ~flush;
    assign do_write = push & (~full | do_read) & ~flush;
    assign rd_data  = empty ? fetch_entry_t'('0) : mem[rd_ptr];

    // Entry storage; contents only matter once counted, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch initiator. Owns the fetch PC, reads the combinational
// instruction ROM every cycle, queues {pc, instr} pairs and presents the
// queue head to decode. A redirect flushes the queue and retargets the PC;
// it outranks both push and pop in the same cycle.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic           clk,
    input  logic           reset,
    ifu_prefetch_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);

    ifu_state_e       state;
    ifu_state_e       state_next;
    logic [PC_W-1:0]  pc_q;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   unused_fifo_count;
    logic [1:0]       unused_redirect_lsb;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head_entry;

    assign unused_redirect_lsb = bus.redirect_pc[1:0];

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = bus.if_instr;

    assign bus.if_pc     = pc_q;
    assign bus.dec_valid = head_valid;
    assign bus.dec_pc    = head_entry.pc;
    assign bus.dec_instr = head_entry.instr;

    // Fetch FSM state register; reset lands in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the push/pop/valid decisions; redirect suppresses both queue moves.
    always_comb begin
        state_next = ST_RUN;
        head_valid = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        if (bus.redirect) begin
            state_next = ST_FLUSH;
        end
        if (state == ST_RUN) begin
            head_valid = ~fifo_empty;
        end
        pop  = head_valid & bus.dec_ready & ~bus.redirect;
        push = ~bus.redirect & (~fifo_full | pop);
    end

    // Fetch PC: redirect target, else advance on every accepted fetch, else hold and re-read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (bus.redirect) begin
            pc_q <= align_pc(bus.redirect_pc);
        end else if (push) begin
            pc_q <= next_pc(pc_q);
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .count   (unused_fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed testbench for ifu_prefetch. The ROM returns the word index
// relative to 0x3000, so every instruction identifies its own fetch address.
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   fail_count;

    ifu_prefetch_if bus();

    ifu_prefetch #(
        .RESET_PC (32'h0000_3000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [31:0] offset;
        offset = pc - 32'h0000_3000;
        return {2'b00, offset[31:2]};
    endfunction

    assign bus.if_instr = rom_word(bus.if_pc);

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir,
                                 input logic [31:0] redir_pc);
        bus.dec_ready   = ready;
        bus.redirect    = redir;
        bus.redirect_pc = redir_pc;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectHead(input string tag, input logic [31:0] pc);
        checkOutput({tag, " valid"}, {31'd0, bus.dec_valid}, 32'd1);
        checkOutput({tag, " pc"}, bus.dec_pc, pc);
        checkOutput({tag, " instr"}, bus.dec_instr, rom_word(pc));
    endtask

    task automatic resetDut();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #7;
        checkOutput("rst if_pc", bus.if_pc, 32'h0000_3000);
        checkOutput("rst dec_valid", {31'd0, bus.dec_valid}, 32'd0);
        checkOutput("rst dec_pc", bus.dec_pc, 32'd0);
        checkOutput("rst dec_instr", bus.dec_instr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        tests_run  = 0;
        fail_count = 0;

        // Streaming with decode always ready: one entry per cycle.
        resetDut();
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            expectHead("t1 stream", 32'h0000_3000 + 32'(4 * i));
        end

        // Decode stalled: queue fills at two entries, PC holds, order kept.
        resetDut();
        stepCycle();
        stepCycle();
        checkOutput("t2 if_pc full", bus.if_pc, 32'h0000_3008);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("t2 if_pc hold", bus.if_pc, 32'h0000_3008);
            expectHead("t2 stable", 32'h0000_3000);
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("t2 drain0", 32'h0000_3000);
        stepCycle();
        expectHead("t2 drain1", 32'h0000_3004);
        stepCycle();
        expectHead("t2 drain2", 32'h0000_3008);

        // Redirect while full, misaligned target.
        resetDut();
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'h0000_3043);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t3 if_pc", bus.if_pc, 32'h0000_3040);
        checkOutput("t3 bubble", {31'd0, bus.dec_valid}, 32'd0);
        stepCycle();
        expectHead("t3 first", 32'h0000_3040);
        stepCycle();
        expectHead("t3 second", 32'h0000_3044);

        // Back-to-back redirects: only the second target stream appears.
        applyStimulus(1'b1, 1'b1, 32'h0000_3100);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 32'h0000_3200);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4 if_pc", bus.if_pc, 32'h0000_3200);
        checkOutput("t4 bubble", {31'd0, bus.dec_valid}, 32'd0);
        stepCycle();
        expectHead("t4 first", 32'h0000_3200);
        stepCycle();
        expectHead("t4 second", 32'h0000_3204);

        // PC wraps modulo 2^32.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t5 bubble", {31'd0, bus.dec_valid}, 32'd0);
        stepCycle();
        expectHead("t5 fff8", 32'hFFFF_FFF8);
        stepCycle();
        expectHead("t5 fffc", 32'hFFFF_FFFC);
        stepCycle();
        expectHead("t5 wrap", 32'h0000_0000);

        // Asynchronous reset mid-stream, between clock edges.
        #3;
        reset = 1'b0;
        #1;
        checkOutput("t6 if_pc", bus.if_pc, 32'h0000_3000);
        checkOutput("t6 dec_valid", {31'd0, bus.dec_valid}, 32'd0);
        checkOutput("t6 dec_pc", bus.dec_pc, 32'd0);
        checkOutput("t6 dec_instr", bus.dec_instr, 32'd0);
        #3;
        reset = 1'b1;
        stepCycle();
        expectHead("t6 restart0", 32'h0000_3000);
        stepCycle();
        expectHead("t6 restart1", 32'h0000_3004);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
